// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: strips leading (dir=0) or trailing (dir=1) zeros one binary
// stage per clock, largest stage first, and reports the total shift applied.
module seq_normalizer #(
   parameter int NUM_STAGE = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2**NUM_STAGE-1:0]  data_in,
   input  logic                     dir,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2**NUM_STAGE-1:0]  data_out,
   output logic [NUM_STAGE-1:0]     shift_amt,
   output logic                     zero
);

   localparam int W  = 2**NUM_STAGE;
   localparam int KW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state, state_nxt;
   logic [W-1:0]           work, work_nxt;
   logic [NUM_STAGE-1:0]   amt, amt_nxt;
   logic [KW-1:0]          k, k_nxt;
   logic                   dir_q, dir_nxt;
   logic                   zero_q, zero_nxt;
   logic [W-1:0]           hi_part, lo_part;
   int unsigned            span;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         work   <= '0;
         amt    <= '0;
         k      <= KW'(NUM_STAGE - 1);
         dir_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         work   <= work_nxt;
         amt    <= amt_nxt;
         k      <= k_nxt;
         dir_q  <= dir_nxt;
         zero_q <= zero_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      work_nxt  = work;
      amt_nxt   = amt;
      k_nxt     = k;
      dir_nxt   = dir_q;
      zero_nxt  = zero_q;
      // hi_part/lo_part keep only the 2**k bits tested by the current stage
      span      = 32'd1 << k;
      hi_part   = work >> (W - span);
      lo_part   = work << (W - span);
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               work_nxt  = data_in;
               dir_nxt   = dir;
               amt_nxt   = '0;
               k_nxt     = KW'(NUM_STAGE - 1);
               zero_nxt  = (data_in == '0);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (!dir_q && (hi_part == '0)) begin
               work_nxt   = work << span;
               amt_nxt[k] = 1'b1;
            end else if (dir_q && (lo_part == '0)) begin
               work_nxt   = work >> span;
               amt_nxt[k] = 1'b1;
            end
            if (k == '0) state_nxt = DONE;
            else         k_nxt     = k - KW'(1);
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign data_out  = work;
   assign shift_amt = amt;
   assign zero      = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer (NUM_STAGE=3): vector table plus backpressure
// and mid-operation reset sequences.
module tb_seq_normalizer;

   localparam int NS = 3;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  data_in = '0;
   logic          dir = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  data_out;
   logic [NS-1:0] shift_amt;
   logic          zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          dir;
      logic [W-1:0]  din;
      logic [W-1:0]  exp_data;
      int            exp_amt;
      logic          exp_zero;
   } vec_t;

   vec_t vecs [10];

   seq_normalizer #(.NUM_STAGE(NS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .dir(dir), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .shift_amt(shift_amt), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept one word (in_ready assumed high), then wait for out_valid and return edge count.
   task automatic send_and_wait(input logic d, input logic [W-1:0] din, output int lat);
      @(negedge clk);
      chk("in_ready_before_load", int'(in_ready), 1);
      in_valid = 1'b1;
      dir      = d;
      data_in  = din;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      out_ready = 1'b1;
      send_and_wait(v.dir, v.din, lat);
      chk({tag, "_latency"}, lat, NS);
      chk({tag, "_data"}, int'(data_out), int'(v.exp_data));
      chk({tag, "_amt"}, int'(shift_amt), v.exp_amt);
      chk({tag, "_zero"}, int'(zero), int'(v.exp_zero));
      @(negedge clk);
      chk({tag, "_out_valid_cleared"}, int'(out_valid), 0);
      chk({tag, "_in_ready_back"}, int'(in_ready), 1);
   endtask

   initial begin
      int lat;
      vecs[0] = '{1'b0, 8'h13, 8'h98, 3, 1'b0};
      vecs[1] = '{1'b0, 8'h01, 8'h80, 7, 1'b0};
      vecs[2] = '{1'b0, 8'h80, 8'h80, 0, 1'b0};
      vecs[3] = '{1'b1, 8'h68, 8'h0D, 3, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 7, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 8'h00, 7, 1'b1};
      vecs[6] = '{1'b1, 8'h00, 8'h00, 7, 1'b1};
      vecs[7] = '{1'b1, 8'h13, 8'h13, 0, 1'b0};
      vecs[8] = '{1'b0, 8'h0F, 8'hF0, 4, 1'b0};
      vecs[9] = '{1'b1, 8'hF0, 8'h0F, 4, 1'b0};

      // reset state
      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_shift_amt", int'(shift_amt), 0);
      chk("rst_zero", int'(zero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // backpressure: hold result, ignore held upstream word, single handshake
      out_ready = 1'b0;
      send_and_wait(1'b0, 8'h01, lat);
      chk("bp_latency", lat, NS);
      in_valid = 1'b1;
      dir      = 1'b0;
      data_in  = 8'h13;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", c), int'(out_valid), 1);
         chk($sformatf("bp_hold%0d_data", c), int'(data_out), 8'h80);
         chk($sformatf("bp_hold%0d_amt", c), int'(shift_amt), 7);
         chk($sformatf("bp_hold%0d_in_ready", c), int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_after_hs_out_valid", int'(out_valid), 0);
      chk("bp_after_hs_in_ready", int'(in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_accepted", int'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("bp_next_latency", lat, NS);
      chk("bp_next_data", int'(data_out), 8'h98);
      chk("bp_next_amt", int'(shift_amt), 3);
      @(negedge clk);

      // reset during SHIFT at k=1
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1;
      dir      = 1'b0;
      data_in  = 8'h01;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_data_out", int'(data_out), 0);
      chk("midrst_shift_amt", int'(shift_amt), 0);
      chk("midrst_zero", int'(zero), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0], "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
Multi-cycle normalizer that reverses a logical barrel shift. The block counts leading zeros (or trailing zeros) of a 2**NUM_STAGE-bit word and shifts the word until its MSB (or LSB) is 1. It resolves one binary shift stage per clock, largest stage first. It sits downstream of the team's barrel shifters and returns both the normalized word and the shift amount that recovers it.

Parameters:
NUM_STAGE, 3, number of shift stages; data width W = 2**NUM_STAGE; shift_amt width = NUM_STAGE.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_in/dir valid
in_ready  output  1  block can accept a word
data_in  input  W  word to normalize
dir  input  1  0 = left-normalize (leading zeros, shift left); 1 = right-normalize (trailing zeros, logical shift right)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
data_out  output  W  normalized word
shift_amt  output  NUM_STAGE  number of bit positions shifted
zero  output  1  data_in was all zeros

Behaviour:
- Reset (rst_n low, async): state=IDLE, out_valid=0, data_out=0, shift_amt=0, zero=0, stage index k=NUM_STAGE-1, latched dir=0. Reset mid-operation aborts the word with no output.
- in_ready = (state==IDLE), combinational from state. It is 1 out of reset. While rst_n is low, inputs are ignored.
- IDLE: on a clock edge with in_valid&in_ready:
  - work <= data_in, dir_q <= dir, amt <= 0, k <= NUM_STAGE-1, zero <= (data_in==0).
  - state <= SHIFT.
- SHIFT: one stage per edge.
  - dir_q=0: if work[W-1 -: 2**k] == 0, then work <= work << 2**k and amt[k] <= 1.
  - dir_q=1: if work[2**k-1:0] == 0, then work <= work >> 2**k and amt[k] <= 1. Zero-fill is logical.
  - Otherwise work and amt are unchanged.
  - If k==0, state <= DONE; otherwise k <= k-1.
- DONE: out_valid=1. data_out=work, shift_amt=amt, zero=zero flag. All three are registered and held stable while out_valid&!out_ready.
  - On out_valid&out_ready: out_valid <= 0, state <= IDLE.
  - In the same edge, in_ready is still 0, so no input is accepted.
- Latency: if accepted at edge t, out_valid is high after edge t+NUM_STAGE. Throughput is one word per NUM_STAGE+2 cycles when out_ready is held high.
- All-zero input: every stage shifts, so shift_amt = 2**NUM_STAGE-1, data_out=0, zero=1, for either dir.
- Already-normalized input (MSB=1 with dir=0, or LSB=1 with dir=1): shift_amt=0, data_out=data_in, zero=0. SHIFT still takes the full NUM_STAGE cycles; there is no early exit.
- data_out/shift_amt are don't-care when out_valid=0, but must equal their last-presented values until the next load.
- in_valid while busy is ignored; the upstream holds the word, per valid/ready rules.

Test Plan:
1. NUM_STAGE=3, dir=0, data_in=0x13, out_ready=1 -> out_valid 3 edges after accept, data_out=0x98, shift_amt=3, zero=0; in_ready returns high the cycle after the output handshake.
2. dir=0, data_in=0x01 -> data_out=0x80, shift_amt=7. dir=0, data_in=0x80 -> data_out=0x80, shift_amt=0, latency still 3.
3. dir=1, data_in=0x68 -> data_out=0x0D, shift_amt=3. dir=1, data_in=0x80 -> data_out=0x01, shift_amt=7.
4. data_in=0x00, both dir values -> data_out=0x00, shift_amt=7, zero=1.
5. Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> single handshake, next word accepted one cycle later.
6. Assert rst_n low during SHIFT (k=1) -> out_valid=0, outputs 0, in_ready=1 immediately. After release, a fresh 0x13 (dir=0) gives 0x98/3 with no residue from the aborted word.
